// File: rtl/axi_slv_wresp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_tb_pkg
// Description : Shared response codes, queue entry types and LFSR seed for
//               the AXI3 slave write responder.
// Revision    : 1.0
// ============================================================================
package axi_tb_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam int unsigned c_ID_W      = 4;
  localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic [c_ID_W-1:0] id;
    logic [3:0]        len;
  } aw_ent_t;

  typedef struct packed {
    logic [c_ID_W-1:0] id;
    logic [1:0]        resp;
  } b_ent_t;

endpackage
`default_nettype wire

// File: rtl/axi_slv_wresp_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with an extra pointer bit separating full
//               from empty; head entry is presented combinationally.
// Revision    : 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [c_AW:0]      r_wr_ptr;
  logic [c_AW:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
        r_wr_ptr                  <= r_wr_ptr + 1'b1;
      end
      if (i_pop && !o_empty) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/axi_slv_wresp.sv
`default_nettype none
// ============================================================================
// Module      : axi_slv_wresp
// Description : AXI3 slave write responder: in-order AW queue, W beat
//               checking against the head request, in-order B responses.
//               Optional macro AXI_SLV_RAND_READY_EN adds LFSR ready throttling.
// Revision    : 1.0
// ============================================================================
module axi_slv_wresp
  import axi_tb_pkg::*;
#(
  parameter int AXI_ID_W        = 4,
  parameter int AXI_DATA_W      = 32,
  parameter int SLV_OSTDREQ_NUM = 4
) (
  input  logic                    aclk,
  input  logic                    srst,
  input  logic                    in_awvalid,
  output logic                    out_awready,
  input  logic [AXI_ID_W-1:0]     in_awid,
  input  logic [3:0]              in_awlen,
  input  logic                    in_wvalid,
  output logic                    out_wready,
  input  logic [AXI_ID_W-1:0]     in_wid,
  input  logic [AXI_DATA_W-1:0]   in_wdata,
  input  logic [AXI_DATA_W/8-1:0] in_wstrb,
  input  logic                    in_wlast,
  output logic                    out_bvalid,
  input  logic                    in_bready,
  output logic [AXI_ID_W-1:0]     out_bid,
  output logic [1:0]              out_bresp,
  output logic [15:0]             out_err_cnt
);

  localparam int c_AW_W = AXI_ID_W + 4;
  localparam int c_B_W  = AXI_ID_W + 2;

  logic [c_AW_W-1:0]   w_aw_head;
  logic [c_B_W-1:0]    w_b_head;
  logic                w_aw_full, w_aw_empty, w_b_full, w_b_empty;
  logic [AXI_ID_W-1:0] w_head_id;
  logic [3:0]          w_head_len;
  logic                w_aw_push, w_w_fire, w_last_beat, w_burst_end;
  logic                w_beat_err, w_err_next, w_b_pop;
  logic [1:0]          w_b_resp;
  logic                w_aw_gate, w_w_gate;
  logic [3:0]          r_beat_cnt;
  logic                r_err_acc;
  logic [15:0]         r_err_cnt;
  logic                w_unused_data;

  // Write payload is a pure sink.
  assign w_unused_data = ^{in_wdata, in_wstrb};

`ifdef AXI_SLV_RAND_READY_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_lfsr <= c_LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_aw_gate = r_lfsr[1];
  assign w_w_gate  = r_lfsr[0];
`else
  assign w_aw_gate = 1'b1;
  assign w_w_gate  = 1'b1;
`endif

  assign out_awready = !w_aw_full && w_aw_gate;
  assign out_wready  = !w_aw_empty && !w_b_full && w_w_gate;

  assign w_head_id   = w_aw_head[c_AW_W-1:4];
  assign w_head_len  = w_aw_head[3:0];
  assign w_aw_push   = in_awvalid && out_awready;
  assign w_w_fire    = in_wvalid && out_wready;
  // Burst length comes from awlen; wlast is only checked, never trusted.
  assign w_last_beat = (r_beat_cnt == w_head_len);
  assign w_burst_end = w_w_fire && w_last_beat;
  assign w_beat_err  = (in_wid != w_head_id) || (in_wlast != w_last_beat);
  assign w_err_next  = r_err_acc || w_beat_err;
  assign w_b_resp    = w_err_next ? RESP_SLVERR : RESP_OKAY;
  assign w_b_pop     = out_bvalid && in_bready;

  sync_fifo #(
    .WIDTH (c_AW_W),
    .DEPTH (SLV_OSTDREQ_NUM)
  ) u_aw_fifo (
    .clk     (aclk),
    .rst     (srst),
    .i_push  (w_aw_push),
    .i_pop   (w_burst_end),
    .i_data  ({in_awid, in_awlen}),
    .o_data  (w_aw_head),
    .o_full  (w_aw_full),
    .o_empty (w_aw_empty)
  );

  sync_fifo #(
    .WIDTH (c_B_W),
    .DEPTH (SLV_OSTDREQ_NUM)
  ) u_b_fifo (
    .clk     (aclk),
    .rst     (srst),
    .i_push  (w_burst_end),
    .i_pop   (w_b_pop),
    .i_data  ({w_head_id, w_b_resp}),
    .o_data  (w_b_head),
    .o_full  (w_b_full),
    .o_empty (w_b_empty)
  );

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_beat_cnt <= '0;
      r_err_acc  <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (w_w_fire) begin
        r_beat_cnt <= w_last_beat ? 4'd0 : r_beat_cnt + 4'd1;
        r_err_acc  <= w_last_beat ? 1'b0 : w_err_next;
      end
      if (w_burst_end && w_err_next && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign out_bvalid  = !w_b_empty;
  assign out_bid     = w_b_head[c_B_W-1:2];
  assign out_bresp   = w_b_head[1:0];
  assign out_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axi_slv_wresp.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_slv_wresp
// Description : Directed self-checking bench for axi_slv_wresp.
// Revision    : 1.0
// ============================================================================
module tb_axi_slv_wresp;
  import axi_tb_pkg::*;

  localparam int c_NRAND = 64;

  logic        aclk = 1'b0;
  logic        srst = 1'b1;
  logic        in_awvalid = 1'b0;
  logic        out_awready;
  logic [3:0]  in_awid = '0;
  logic [3:0]  in_awlen = '0;
  logic        in_wvalid = 1'b0;
  logic        out_wready;
  logic [3:0]  in_wid = '0;
  logic [31:0] in_wdata = '0;
  logic [3:0]  in_wstrb = '0;
  logic        in_wlast = 1'b0;
  logic        out_bvalid;
  logic        in_bready = 1'b1;
  logic [3:0]  out_bid;
  logic [1:0]  out_bresp;
  logic [15:0] out_err_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  b_ent_t      got_b[$];
  aw_ent_t     exp_all[c_NRAND];
  int          aw_sent;
  bit          w_done;

  axi_slv_wresp u_dut (
    .aclk        (aclk),
    .srst        (srst),
    .in_awvalid  (in_awvalid),
    .out_awready (out_awready),
    .in_awid     (in_awid),
    .in_awlen    (in_awlen),
    .in_wvalid   (in_wvalid),
    .out_wready  (out_wready),
    .in_wid      (in_wid),
    .in_wdata    (in_wdata),
    .in_wstrb    (in_wstrb),
    .in_wlast    (in_wlast),
    .out_bvalid  (out_bvalid),
    .in_bready   (in_bready),
    .out_bid     (out_bid),
    .out_bresp   (out_bresp),
    .out_err_cnt (out_err_cnt)
  );

  always #5 aclk = ~aclk;

  // Record every completed B handshake in arrival order.
  always @(posedge aclk) begin
    if (!srst && out_bvalid && in_bready) begin
      got_b.push_back(b_ent_t'({out_bid, out_bresp}));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [3:0] len);
    int g;
    in_awvalid = 1'b1;
    in_awid    = id;
    in_awlen   = len;
    g = 0;
    while (!out_awready && g < 200) begin
      tick();
      g++;
    end
    check("aw_handshake", {31'd0, out_awready}, 32'd1);
    tick();
    in_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [3:0] id, input logic last);
    int g;
    in_wvalid = 1'b1;
    in_wid    = id;
    in_wlast  = last;
    in_wdata  = $urandom;
    in_wstrb  = 4'hF;
    g = 0;
    while (!out_wready && g < 200) begin
      tick();
      g++;
    end
    check("w_handshake", {31'd0, out_wready}, 32'd1);
    tick();
    in_wvalid = 1'b0;
    in_wlast  = 1'b0;
  endtask

  initial begin
    logic [5:0] e;

    // Reset state
    tick();
    tick();
    srst = 1'b0;
    check("rst_awready", {31'd0, out_awready}, 32'd1);
    check("rst_wready",  {31'd0, out_wready},  32'd0);
    check("rst_bvalid",  {31'd0, out_bvalid},  32'd0);
    check("rst_bid",     {28'd0, out_bid},     32'd0);
    check("rst_bresp",   {30'd0, out_bresp},   32'd0);
    check("rst_errcnt",  {16'd0, out_err_cnt}, 32'd0);

    // Single burst id=5 len=3
    send_aw(4'h5, 4'd3);
    send_w(4'h5, 1'b0);
    send_w(4'h5, 1'b0);
    send_w(4'h5, 1'b0);
    check("single_no_early_b", {31'd0, out_bvalid}, 32'd0);
    send_w(4'h5, 1'b1);
    check("single_bvalid", {31'd0, out_bvalid}, 32'd1);
    check("single_bid",    {28'd0, out_bid},    32'h5);
    check("single_bresp",  {30'd0, out_bresp},  32'd0);
    tick();
    check("single_b_count", got_b.size(), 32'd1);
    check("single_errcnt",  {16'd0, out_err_cnt}, 32'd0);
    got_b.delete();

    // Queue fill: four single-beat AWs, no W yet
    for (int i = 1; i <= 4; i++) send_aw(i[3:0], 4'd0);
    check("fill_awready_low", {31'd0, out_awready}, 32'd0);
    send_w(4'h1, 1'b1);
    check("fill_awready_back", {31'd0, out_awready}, 32'd1);
    for (int i = 2; i <= 4; i++) send_w(i[3:0], 1'b1);
    tick();
    tick();
    check("fill_b_count", got_b.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      e = {i[3:0] + 4'd1, RESP_OKAY};
      if (i < got_b.size()) check("fill_b_order", {26'd0, got_b[i]}, {26'd0, e});
    end
    got_b.delete();

    // Early wlast on beat 2 of a 3-beat burst
    send_aw(4'h6, 4'd2);
    send_w(4'h6, 1'b0);
    send_w(4'h6, 1'b1);
    check("early_no_b_yet", {31'd0, out_bvalid}, 32'd0);
    send_w(4'h6, 1'b1);
    check("early_bvalid", {31'd0, out_bvalid}, 32'd1);
    check("early_bid",    {28'd0, out_bid},    32'h6);
    check("early_bresp",  {30'd0, out_bresp},  32'h2);
    check("early_errcnt", {16'd0, out_err_cnt}, 32'd1);
    tick();
    got_b.delete();

    // B backpressure: fill the B queue
    in_bready = 1'b0;
    for (int i = 7; i <= 10; i++) begin
      send_aw(i[3:0], 4'd1);
      send_w(i[3:0], 1'b0);
      send_w(i[3:0], 1'b1);
    end
    send_aw(4'hB, 4'd0);
    check("bp_wready_low", {31'd0, out_wready}, 32'd0);
    check("bp_bvalid",     {31'd0, out_bvalid}, 32'd1);
    check("bp_head_bid",   {28'd0, out_bid},    32'h7);
    in_bready = 1'b1;
    tick();
    check("bp_wready_back", {31'd0, out_wready}, 32'd1);
    send_w(4'hB, 1'b1);
    repeat (6) tick();
    check("bp_b_count", got_b.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      e = {i[3:0] + 4'd7, RESP_OKAY};
      if (i < got_b.size()) check("bp_b_order", {26'd0, got_b[i]}, {26'd0, e});
    end
    got_b.delete();

    // Concurrent AW / W / B traffic
    for (int k = 0; k < c_NRAND; k++) begin
      exp_all[k].id  = 4'($urandom_range(0, 15));
      exp_all[k].len = 4'($urandom_range(0, 3));
    end
    aw_sent = 0;
    w_done  = 1'b0;
    fork
      begin
        for (int k = 0; k < c_NRAND; k++) begin
          send_aw(exp_all[k].id, exp_all[k].len);
          aw_sent++;
          repeat ($urandom_range(0, 1)) tick();
        end
      end
      begin
        for (int k = 0; k < c_NRAND; k++) begin
          int g = 0;
          while (aw_sent <= k && g < 200) begin
            tick();
            g++;
          end
          check("rand_aw_ready_for_w", {31'd0, aw_sent > k}, 32'd1);
          for (int b = 0; b <= int'(exp_all[k].len); b++) begin
            send_w(exp_all[k].id, b == int'(exp_all[k].len));
          end
        end
        w_done = 1'b1;
      end
      begin
        int g = 0;
        while (!w_done && g < 5000) begin
          in_bready = 1'($urandom_range(0, 1));
          tick();
          g++;
        end
        in_bready = 1'b1;
      end
    join
    begin
      int g = 0;
      while (out_bvalid && g < 50) begin
        tick();
        g++;
      end
    end
    tick();
    check("rand_b_count", got_b.size(), c_NRAND);
    for (int k = 0; k < c_NRAND; k++) begin
      e = {exp_all[k].id, RESP_OKAY};
      if (k < got_b.size()) check("rand_b_entry", {26'd0, got_b[k]}, {26'd0, e});
    end
    check("rand_errcnt", {16'd0, out_err_cnt}, 32'd1);
    got_b.delete();

    // Reset in the middle of an 8-beat burst
    send_aw(4'h3, 4'd7);
    send_w(4'h3, 1'b0);
    send_w(4'h3, 1'b0);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("mid_rst_bvalid",  {31'd0, out_bvalid},  32'd0);
    check("mid_rst_wready",  {31'd0, out_wready},  32'd0);
    check("mid_rst_awready", {31'd0, out_awready}, 32'd1);
    check("mid_rst_errcnt",  {16'd0, out_err_cnt}, 32'd0);
    send_aw(4'hC, 4'd0);
    send_w(4'hC, 1'b1);
    check("post_rst_bvalid", {31'd0, out_bvalid}, 32'd1);
    check("post_rst_bid",    {28'd0, out_bid},    32'hC);
    check("post_rst_bresp",  {30'd0, out_bresp},  32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_slv_wresp.md
Name: axi_slv_wresp

Overview:
- Synthesizable AXI3 slave-side write responder; the opposite end of the master write-data driver.
- Accepts AW requests and queues {awid, awlen} in order, then consumes W beats for the head request and checks wid/wlast/beat count against it.
- Issues one B response per burst, in order, with bid = awid.
- Sits at each crossbar slave port in the bench, so the interconnect can be stressed without a memory model.

Parameters:
- AXI_ID_W, 4, ID width of awid/wid/bid.
- AXI_DATA_W, 32, W data width; wstrb width is AXI_DATA_W/8.
- SLV_OSTDREQ_NUM, 4, depth of the AW queue and of the B queue; must be a power of 2, at least 2.

Ports:
- aclk  in  1  clock.
- srst  in  1  synchronous active-high reset.
- in_awvalid  in  1  AW valid.
- out_awready  out  1  AW ready.
- in_awid  in  AXI_ID_W  AW id.
- in_awlen  in  4  AW burst length minus 1.
- in_wvalid  in  1  W valid.
- out_wready  out  1  W ready.
- in_wid  in  AXI_ID_W  W id.
- in_wdata  in  AXI_DATA_W  W data; data sink only.
- in_wstrb  in  AXI_DATA_W/8  W strobes; data sink only.
- in_wlast  in  1  W last.
- out_bvalid  out  1  B valid.
- in_bready  in  1  B ready.
- out_bid  out  AXI_ID_W  B id.
- out_bresp  out  2  B response.
- out_err_cnt  out  16  count of bursts answered with SLVERR; saturates at 16'hFFFF.

Behaviour:
- Reset: aclk and srst only; srst is synchronous and active-high. All queues are emptied and all pointers, counters and the beat counter clear to 0. After reset: out_awready=1, out_wready=0, out_bvalid=0, out_bid=0, out_bresp=0, out_err_cnt=0.
- srst mid-burst: partial bursts and queued B responses are discarded; there is no flush handshake.
- AW queue: FIFO of {awid, awlen} with ptr width $clog2(SLV_OSTDREQ_NUM)+1; the MSB distinguishes full from empty.
  - out_awready = !aw_full, combinational from registered state.
  - Push on in_awvalid && out_awready.
  - Push and pop in the same cycle are legal: occupancy is unchanged and pointers wrap modulo depth.
- W acceptance: out_wready = !aw_empty && !b_full.
  - A W beat that arrives before its AW stalls; no W-before-AW buffering.
- Beat counter beat_cnt (4 bits):
  - Increments on each accepted W beat.
  - Burst ends on the accepted beat where beat_cnt == head awlen (length-driven, not wlast-driven). beat_cnt then returns to 0 and the AW head pops in the same cycle.
- Error flag err_acc: set for the burst if any of the following occurs, and cleared at burst end.
  - in_wid != head awid on any beat.
  - in_wlast=1 on a non-final beat.
  - in_wlast=0 on the final beat.
- B queue: at burst end, push {head awid, err_acc_next ? 2'b10 SLVERR : 2'b00 OKAY}.
  - Push is allowed because out_wready already guaranteed !b_full.
  - out_bvalid = !b_empty; out_bid/out_bresp come from the head entry and are held stable while out_bvalid && !in_bready. Pop on out_bvalid && in_bready.
- Latency:
  - The B response for a burst is visible the cycle after its final W beat handshakes, if the B queue was empty.
  - awlen=0 with AW already queued gives a single-beat burst whose B appears one cycle after the W handshake.
- out_err_cnt increments at B push with SLVERR; it does not count at pop.
- No reordering: responses are strictly in AW order.

Optional Feature:
- Macro AXI_SLV_RAND_READY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on srst) advances every cycle.
  - out_wready additionally requires lfsr[0]=1; in_bready is unaffected.
  - out_awready additionally requires lfsr[1]=1.
- Undefined: no LFSR; ready signals are exactly as in Behaviour.

Decomposition:
- Package axi_tb_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - typedef aw_ent_t {id, len}.
  - typedef b_ent_t {id, resp}.
  - LFSR seed constant.
- Sub-module sync_fifo #(WIDTH, DEPTH): one clock, srst, push/pop, full/empty flags, data out from the head. It is instantiated twice, once for AW and once for B.

Test Plan:
- Single burst: AW id=4'h5 len=3, then 4 W beats wid=5 with wlast on beat 4, bready=1 -> exactly one B, bid=5, bresp=OKAY, one cycle after beat 4; err_cnt=0.
- Queue fill: 4 AWs (ids 1..4, len=0) with no W -> awready=0 after the 4th. Then one W -> awready=1 next cycle; B order is 1,2,3,4.
- Early wlast: AW len=2, wlast on beat 2 -> burst still ends on beat 3; bresp=SLVERR; err_cnt=1.
- B backpressure: bready=0 and 4 completed bursts -> wready=0 while AW is pending. Then bready=1 -> B drains in order and wready reasserts.
- Simultaneous events: AW push and B pop in the same cycle, with a W final beat alongside -> no lost or duplicated entries across 64 random bursts; B count equals AW count.
- Reset mid-burst: srst after beat 2 of len=7 -> next cycle bvalid=0, wready=0, awready=1. A fresh AW len=0 then completes with OKAY.
